sha256_header_feeder: RTL and testbench
=======================================

# sha256_header_feeder

Upstream sequencer for the `sha256` compression core. It accepts an 80-byte block header and splits it into two padded 512-bit chunks, then drives the core's `enable`/`data`/`current_hash` handshake for each chunk. It chains the midstate between chunks and returns the final 256-bit digest. It sits between the work-loading logic and the SHA-256 core in the hashing pipeline.

## Interface
Parameters: none; all constants come from `sha256_pkg`.

Ports:
- `clk` in 1: single clock, shared with the core.
- `rst` in 1: asynchronous, active-high reset. The top level drives the core's `n_rst` from `~rst`, so both blocks always reset together.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `header` in 640: block header, byte 0 in bits [639:632]; latched when `start` is accepted.
- `busy` out 1: high in every state except IDLE.
- `core_enable` out 1: pulse to the core's `enable`.
- `core_data` out 512: chunk driven to the core's `data`; registered.
- `core_current_hash` out 256: chaining value driven to the core's `current_hash`; registered.
- `core_hash` in 256: the core's `hash` output.
- `core_hash_done` in 1: the core's `hash_done` output.
- `midstate` out 256: hash state after chunk 0; valid with `digest_valid`.
- `digest` out 256: final digest.
- `digest_valid` out 1: one-cycle pulse.

## Operation
- States, in order: IDLE, REQ0, WAIT0, REQ1, WAIT1, [REQ2, WAIT2], OUT.
- **IDLE**
  - If `start` is high: latch `header` and go to REQ0.
  - `start` in any other state is ignored; it is not queued.
- **REQ0**
  - `core_data = header_q[639:128]`.
  - `core_current_hash = SHA256_H0`.
  - `core_enable = 1` for this cycle only. Next state is WAIT0.
- **WAIT0**
  - Hold all core inputs stable; the core samples them on the cycle after `enable`.
  - On `core_hash_done`: capture `core_hash` into `midstate_q`, then go to REQ1.
- **REQ1**
  - `core_data = {header_q[127:0], 8'h80, 312'b0, 64'd640}`.
  - `core_current_hash = midstate_q`.
  - `core_enable = 1`. Next state is WAIT1.
- **WAIT1**
  - On `core_hash_done`: capture `core_hash` into `digest_q`.
  - Next state is OUT, or REQ2 when the double-hash option is enabled.
- **REQ2 / WAIT2** (built only with `SHA256_DOUBLE_EN`; see Configuration)
  - `core_data = {digest_q, 8'h80, 184'b0, 64'd256}`.
  - `core_current_hash = SHA256_H0`.
  - On `core_hash_done`: capture into `digest_q`, then go to OUT.
- **OUT**
  - `digest_valid = 1`, `digest = digest_q`, `midstate = midstate_q`. Next state is IDLE.
- `digest` and `midstate` hold their values until the next accepted `start` overwrites them.
- `core_hash_done` is ignored outside WAIT states.
- Padding arithmetic:
  - Message length fields are 64-bit big-endian bit counts: 640 and 256.
  - All chunk and hash widths are exact; no truncation.

## Timing
- Reset values:
  - State is IDLE.
  - `busy`, `core_enable` and `digest_valid` are 0.
  - `core_data`, `core_current_hash`, `midstate` and `digest` are 0.
- Reset mid-operation aborts immediately to IDLE with reset values. Because the core resets together with this block, no stale `hash_done` follows.
- Cycle numbering: `start` is sampled at edge 0, and REQ0 occupies cycle 1.
- Core latency is 67 cycles from the enable cycle to `hash_done`: INIT 1, COMPRESS 16, EXT_COMPRESS 48, POST 1, then DONE.
- Single hash:
  - `core_hash_done` at cycle 68; REQ1 at 69.
  - Second `core_hash_done` at 136.
  - `digest_valid` at cycle 137.
- Double hash: REQ2 at 137, `core_hash_done` at 204, `digest_valid` at 205.
- `start` can be accepted in the cycle after OUT at the earliest. `start` held high in IDLE begins a new run every time the block returns to IDLE.
- The core leaves DONE on the next `enable`; REQ states always follow a DONE cycle, so no extra gap cycle is needed.

## Configuration
- `SHA256_DOUBLE_EN` defined:
  - REQ2/WAIT2 are built.
  - `digest` = SHA256(SHA256(header)).
  - Start-to-`digest_valid` latency is 205 cycles.
- Undefined:
  - No REQ2/WAIT2 logic.
  - `digest` = SHA256(header).
  - Latency is 137 cycles.
- `midstate` behaves the same in both builds.

## Structure
- `sha256_pkg` holds:
  - `SHA256_H0` (256-bit IV, 6a09e667…5be0cd19).
  - `SHA256_PAD_BYTE = 8'h80`.
  - Length constants 640 and 256.
  - The feeder state enum.
- Sub-module `sha256_pad`: purely combinational. It builds the REQ1 and REQ2 chunk vectors from `header_q[127:0]` and `digest_q`, which keeps the FSM free of wide concatenations.

## Test plan
- Bitcoin genesis header with `SHA256_DOUBLE_EN`:
  - `digest_valid` at cycle 205.
  - `digest` = 6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000.
- All-zero header, single-hash build:
  - `digest` and `midstate` equal the software-model values (hashlib, and the midstate of the first 64 bytes).
  - `digest_valid` at cycle 137.
- Pulse `start` again during WAIT0 with a different header:
  - It is ignored, `busy` stays 1, and the digest matches the first header.
- Assert `rst` at cycle 100 of a run:
  - All outputs are 0 next cycle, with no `digest_valid`.
  - A new `start` then completes correctly.
- Back-to-back runs with `start` held high:
  - The second REQ0 follows OUT by one cycle (cycle 139 with 137-cycle runs).
  - Both digests are correct.
- Protocol check:
  - `core_enable` is high exactly one cycle per chunk.
  - `core_data` and `core_current_hash` are stable from each REQ cycle through the following cycle.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 header feeder.
// REQ2/WAIT2 are only reached when SHA256_DOUBLE_EN is defined.
package sha256_pkg;

    localparam logic [255:0] SHA256_H0 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [7:0]   SHA256_PAD_BYTE = 8'h80;
    localparam logic [63:0]  SHA256_LEN_HDR  = 64'd640;
    localparam logic [63:0]  SHA256_LEN_DIG  = 64'd256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_WAIT0,
        ST_REQ1,
        ST_WAIT1,
        ST_REQ2,
        ST_WAIT2,
        ST_OUT
    } feeder_state_t;

endpackage

// File: rtl/sha256_pad.sv
// Combinational builder for the padded tail chunks (header tail, and the
// 256-bit digest re-hash chunk when SHA256_DOUBLE_EN is defined).
module sha256_pad
    import sha256_pkg::*;
(
    input  logic [127:0] i_hdr_tail,
`ifdef SHA256_DOUBLE_EN
    input  logic [255:0] i_digest,
    output logic [511:0] o_chunk2,
`endif
    output logic [511:0] o_chunk1
);

    assign o_chunk1 = {i_hdr_tail, SHA256_PAD_BYTE, 312'b0, SHA256_LEN_HDR};

`ifdef SHA256_DOUBLE_EN
    assign o_chunk2 = {i_digest, SHA256_PAD_BYTE, 184'b0, SHA256_LEN_DIG};
`endif

endmodule

// File: rtl/sha256_header_feeder.sv
// Sequences an 80-byte header through the SHA-256 core as two chained chunks.
// Define SHA256_DOUBLE_EN to append a third pass hashing the first digest.
module sha256_header_feeder
    import sha256_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [639:0] i_header,
    output logic         o_busy,
    output logic         o_core_enable,
    output logic [511:0] o_core_data,
    output logic [255:0] o_core_current_hash,
    input  logic [255:0] i_core_hash,
    input  logic         i_core_hash_done,
    output logic [255:0] o_midstate,
    output logic [255:0] o_digest,
    output logic         o_digest_valid
);

    feeder_state_t r_state;
    logic [127:0]  r_hdr_tail;
    logic [255:0]  r_midstate;
    logic [255:0]  r_digest;
    logic [511:0]  r_core_data;
    logic [255:0]  r_core_hash_in;
    logic          r_core_enable;
    logic          r_busy;
    logic          r_digest_valid;
    logic [511:0]  w_chunk1;
`ifdef SHA256_DOUBLE_EN
    logic [511:0]  w_chunk2;
`endif

    // The digest chunk is built from the live core output so REQ2 can be
    // issued on the same edge that captures the first digest.
    sha256_pad u_pad (
        .i_hdr_tail (r_hdr_tail),
`ifdef SHA256_DOUBLE_EN
        .i_digest   (i_core_hash),
        .o_chunk2   (w_chunk2),
`endif
        .o_chunk1   (w_chunk1)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_hdr_tail     <= '0;
            r_midstate     <= '0;
            r_digest       <= '0;
            r_core_data    <= '0;
            r_core_hash_in <= '0;
            r_core_enable  <= 1'b0;
            r_busy         <= 1'b0;
            r_digest_valid <= 1'b0;
        end else begin
            r_core_enable  <= 1'b0;
            r_digest_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_hdr_tail     <= i_header[127:0];
                        r_core_data    <= i_header[639:128];
                        r_core_hash_in <= SHA256_H0;
                        r_core_enable  <= 1'b1;
                        r_busy         <= 1'b1;
                        r_state        <= ST_REQ0;
                    end
                end
                ST_REQ0: r_state <= ST_WAIT0;
                ST_WAIT0: begin
                    if (i_core_hash_done) begin
                        r_midstate     <= i_core_hash;
                        r_core_data    <= w_chunk1;
                        r_core_hash_in <= i_core_hash;
                        r_core_enable  <= 1'b1;
                        r_state        <= ST_REQ1;
                    end
                end
                ST_REQ1: r_state <= ST_WAIT1;
                ST_WAIT1: begin
                    if (i_core_hash_done) begin
                        r_digest <= i_core_hash;
`ifdef SHA256_DOUBLE_EN
                        r_core_data    <= w_chunk2;
                        r_core_hash_in <= SHA256_H0;
                        r_core_enable  <= 1'b1;
                        r_state        <= ST_REQ2;
`else
                        r_digest_valid <= 1'b1;
                        r_state        <= ST_OUT;
`endif
                    end
                end
`ifdef SHA256_DOUBLE_EN
                ST_REQ2: r_state <= ST_WAIT2;
                ST_WAIT2: begin
                    if (i_core_hash_done) begin
                        r_digest       <= i_core_hash;
                        r_digest_valid <= 1'b1;
                        r_state        <= ST_OUT;
                    end
                end
`endif
                ST_OUT: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy              = r_busy;
    assign o_core_enable       = r_core_enable;
    assign o_core_data         = r_core_data;
    assign o_core_current_hash = r_core_hash_in;
    assign o_midstate          = r_midstate;
    assign o_digest            = r_digest;
    assign o_digest_valid      = r_digest_valid;

endmodule

// File: tb/tb_sha256_header_feeder.sv
// Bench for sha256_header_feeder: a behavioural SHA-256 core with spec latency,
// plus a byte-level SHA-256 reference model (honours SHA256_DOUBLE_EN).
module tb_sha256_header_feeder;

    localparam logic [255:0] H0 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
`ifdef SHA256_DOUBLE_EN
    localparam int LAT = 205;
`else
    localparam int LAT = 137;
`endif
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk, rst, start;
    logic [639:0] header;
    logic         busy, core_enable, core_done, dvalid;
    logic [511:0] core_data;
    logic [255:0] core_ch, core_hash, midstate, digest;

    sha256_header_feeder dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_start             (start),
        .i_header            (header),
        .o_busy              (busy),
        .o_core_enable       (core_enable),
        .o_core_data         (core_data),
        .o_core_current_hash (core_ch),
        .i_core_hash         (core_hash),
        .i_core_hash_done    (core_done),
        .o_midstate          (midstate),
        .o_digest            (digest),
        .o_digest_valid      (dvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e,  hin[95:64] + f,   hin[63:32] + g,   hin[31:0] + h};
    endfunction

    // Full SHA-256 of an arbitrary byte message, standard padding.
    function automatic logic [255:0] sha_msg(input logic [7:0] m[$]);
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [255:0] hs;
        logic [511:0] blk;
        p = m;
        bits = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        hs = H0;
        for (int bk = 0; bk < p.size() / 64; bk++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*bk+j];
            hs = compress(hs, blk);
        end
        return hs;
    endfunction

    // Behavioural core: samples inputs the cycle after enable, hash_done 67 cycles
    // after the enable cycle, and holds DONE until the next enable.
    int           m_cnt;
    logic [511:0] m_data;
    logic [255:0] m_ch, m_res;
    logic         m_cap_evt, m_cap_ok;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0; core_done <= 1'b0; core_hash <= '0; m_cap_evt <= 1'b0; m_cap_ok <= 1'b0;
        end else begin
            m_cap_evt <= 1'b0;
            if (core_enable) begin
                m_cnt <= 1; core_done <= 1'b0; m_data <= core_data; m_ch <= core_ch;
            end else if (m_cnt != 0) begin
                if (m_cnt == 1) begin
                    m_cap_evt <= 1'b1;
                    m_cap_ok  <= (core_data == m_data) && (core_ch == m_ch);
                    m_res     <= compress(core_ch, core_data);
                end
                if (m_cnt == 66) begin
                    core_done <= 1'b1; core_hash <= m_res; m_cnt <= 0;
                end else m_cnt <= m_cnt + 1;
            end
        end
    end

    // Acceptance model: start is taken only when the previous run is over.
    int           cyc = 0, n_acc = 0, m_next_ok = 0;
    int           acc_cyc [64];
    logic [639:0] acc_hdr [64];
    always @(posedge clk) begin
        if (rst) m_next_ok <= 0;
        else if (start && (cyc + 1) >= m_next_ok) begin
            acc_hdr[n_acc] <= header;
            acc_cyc[n_acc] <= cyc + 1;
            n_acc          <= n_acc + 1;
            m_next_ok      <= cyc + 1 + LAT + 1;
        end
        cyc <= cyc + 1;
    end

    int n_tests = 0, n_fail = 0, rd_idx = 0, n_done = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [255:0] last_dig, ed, em;
        logic [639:0] hdr;
        logic [7:0]   q[$];
        logic         e_busy, e_val, e_en;
        int           s;
        last_dig = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_idx = n_acc;
                last_dig = '0;
                chk("rst busy", 256'(busy), 256'd0);
                chk("rst enable", 256'(core_enable), 256'd0);
                chk("rst valid", 256'(dvalid), 256'd0);
                chk("rst core_data", 256'(|core_data), 256'd0);
                chk("rst core_hash", core_ch, 256'd0);
                chk("rst midstate", midstate, 256'd0);
                chk("rst digest", digest, 256'd0);
                continue;
            end
            e_busy = 1'b0; e_val = 1'b0; e_en = 1'b0; s = 0;
            if (rd_idx < n_acc) begin
                s = acc_cyc[rd_idx];
                e_busy = (cyc >= s) && (cyc <= s + LAT - 1);
                e_val  = (cyc == s + LAT - 1);
                e_en   = (cyc == s) || (cyc == s + 68);
`ifdef SHA256_DOUBLE_EN
                e_en   = e_en || (cyc == s + 136);
`endif
            end
            chk("busy", 256'(busy), 256'(e_busy));
            chk("digest_valid", 256'(dvalid), 256'(e_val));
            chk("core_enable", 256'(core_enable), 256'(e_en));
            if (m_cap_evt) chk("core inputs stable", 256'(m_cap_ok), 256'd1);
            if (e_val) begin
                hdr = acc_hdr[rd_idx];
                q.delete();
                for (int i = 0; i < 80; i++) q.push_back(hdr[639-8*i -: 8]);
                ed = sha_msg(q);
`ifdef SHA256_DOUBLE_EN
                q.delete();
                for (int i = 0; i < 32; i++) q.push_back(ed[255-8*i -: 8]);
                ed = sha_msg(q);
`endif
                em = compress(H0, hdr[639:128]);
                chk("digest", digest, ed);
                chk("midstate", midstate, em);
                last_dig = ed;
                rd_idx++;
                n_done++;
            end else if (!e_busy) begin
                chk("digest hold", digest, last_dig);
            end
        end
    endtask

    task automatic wait_runs(input int target, input int budget);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("run completes", 256'(n_done >= target), 256'd1);
    endtask

    task automatic pulse(input logic [639:0] h);
        @(negedge clk);
        header = h; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [7:0]   pq[$];
    logic [639:0] hinc;
    int           base, k;

    initial begin
        rst = 1'b1; start = 1'b0; header = '0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        chk("reset busy", 256'(busy), 256'd0);
        chk("reset enable", 256'(core_enable), 256'd0);
        chk("reset valid", 256'(dvalid), 256'd0);
        chk("reset core_data", 256'(|core_data), 256'd0);
        chk("reset core_hash", core_ch, 256'd0);
        chk("reset midstate", midstate, 256'd0);
        chk("reset digest", digest, 256'd0);
        #1 rst = 1'b0;

        // Known-answer vectors pin the reference model.
        pq.delete();
        chk("model sha empty", sha_msg(pq),
            256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
        pq.push_back(8'h61); pq.push_back(8'h62); pq.push_back(8'h63);
        chk("model sha abc", sha_msg(pq),
            256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        // All-zero header.
        pulse('0);
        wait_runs(1, 400);

        // Incrementing bytes; a second start during WAIT0 must be ignored.
        for (int i = 0; i < 80; i++) hinc[639-8*i -: 8] = 8'(i);
        pulse(hinc);
        repeat (3) @(negedge clk);
        header = {80{8'hff}}; start = 1'b1;
        @(negedge clk);
        chk("busy during ignored start", 256'(busy), 256'd1);
        start = 1'b0;
        wait_runs(2, 400);

        // Reset in cycle 100 aborts; the same header then completes.
        pulse({20{32'hdeadbeef}});
        repeat (98) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort busy", 256'(busy), 256'd0);
        chk("abort valid", 256'(dvalid), 256'd0);
        chk("abort core_data", 256'(|core_data), 256'd0);
        chk("abort midstate", midstate, 256'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        pulse({20{32'hdeadbeef}});
        wait_runs(3, 400);

        // Start held high: two back-to-back runs with different headers.
        base = n_acc;
        @(negedge clk);
        header = {10{64'h0123456789abcdef}}; start = 1'b1;
        k = 0;
        while (n_acc < base + 1 && k < 10) begin @(negedge clk); k++; end
        header = {80{8'h5a}};
        k = 0;
        while (n_acc < base + 2 && k < LAT + 20) begin @(negedge clk); k++; end
        start = 1'b0;
        chk("back-to-back accepted", 256'(n_acc - base), 256'd2);
        wait_runs(5, 2 * LAT + 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
